// File: rtl/ex_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_pkg
//
// Shared ISA constants and types for the EX-stage multiply/divide unit.
// Holds the machine word width, the SPECIAL opcode, and the funct codes
// for the HI/LO instructions. Also defines the unit's FSM state and
// operation types, and a decoder from (opcode, funct) to operation.
//
// Contents:
//   WORD              machine word width (32)
//   OPCODE_SPECIAL    primary opcode for R-type instructions
//   FUNCT_*           funct codes for MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU
//   muldivState_e     IDLE / DIV / DONE
//   muldivOp_e        decoded operation (OP_NONE for anything else)
//   decodeOp()        opcode/funct -> muldivOp_e
// ---------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

  localparam int WORD = 32;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } muldivState_e;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_MFHI,
    OP_MTHI,
    OP_MFLO,
    OP_MTLO,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } muldivOp_e;

  // Only SPECIAL-opcode instructions with one of the eight HI/LO funct codes
  // involve this unit; everything else decodes to OP_NONE.
  function automatic muldivOp_e decodeOp(input logic [5:0] opcode,
                                         input logic [5:0] funct);
    muldivOp_e result;
    result = OP_NONE;
    if (opcode == OPCODE_SPECIAL) begin
      case (funct)
        FUNCT_MFHI:  result = OP_MFHI;
        FUNCT_MTHI:  result = OP_MTHI;
        FUNCT_MFLO:  result = OP_MFLO;
        FUNCT_MTLO:  result = OP_MTLO;
        FUNCT_MULT:  result = OP_MULT;
        FUNCT_MULTU: result = OP_MULTU;
        FUNCT_DIV:   result = OP_DIV;
        FUNCT_DIVU:  result = OP_DIVU;
        default:     result = OP_NONE;
      endcase
    end
    return result;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_iter.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_div_iter  (the div_iter core)
//
// Iterative unsigned restoring divider: one quotient bit per clock, 32 steps.
// The parent handles all sign/magnitude conversion and the divide-by-zero
// and overflow special cases; this core only sees magnitudes.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset (drops any run in progress)
//   start_i      load operands and begin a new 32-step divide
//   abort_i      abandon the divide in progress
//   dividend_i   unsigned dividend (sampled on start_i)
//   divisor_i    unsigned divisor  (sampled on start_i)
//   quotient_o   quotient after the step being taken this cycle
//   remainder_o  remainder after the step being taken this cycle
//   done_o       high during the cycle that performs the final step;
//                quotient_o/remainder_o then hold the finished result
// ---------------------------------------------------------------------------
module ex_muldiv_unit_div_iter
  import ex_muldiv_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [WORD-1:0] dividend_i,
  input  logic [WORD-1:0] divisor_i,
  output logic [WORD-1:0] quotient_o,
  output logic [WORD-1:0] remainder_o,
  output logic            done_o
);

  localparam logic [4:0] LAST_STEP = 5'd31;

  logic [WORD-1:0] remQ;
  logic [WORD-1:0] quoQ;
  logic [WORD-1:0] divisorQ;
  logic [4:0]      countQ;
  logic            runQ;

  logic [WORD:0]   remShift;
  logic            borrow;
  logic            unusedDiffBit;
  logic [WORD-1:0] diffLow;
  logic [WORD-1:0] remD;
  logic [WORD-1:0] quoD;

  // One restoring step: shift remainder:quotient left, trial-subtract the
  // divisor, keep the difference only when it did not borrow. The shifted
  // remainder can be 33 bits wide, so the subtraction is done in 34 bits and
  // the top bit is the borrow. Bit 32 of a non-borrowing difference is
  // always zero because the new remainder is below the divisor.
  always_comb begin
    remShift = {remQ, quoQ[WORD-1]};
    {borrow, unusedDiffBit, diffLow} = {1'b0, remShift} - {2'b00, divisorQ};
    remD = borrow ? remShift[WORD-1:0] : diffLow;
    quoD = {quoQ[WORD-2:0], ~borrow};
  end

  // Operand registers and step counter. The quotient register starts out
  // holding the dividend; its bits shift into the remainder as quotient
  // bits shift in from the right.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      remQ     <= '0;
      quoQ     <= '0;
      divisorQ <= '0;
      countQ   <= '0;
      runQ     <= 1'b0;
    end else if (start_i) begin
      remQ     <= '0;
      quoQ     <= dividend_i;
      divisorQ <= divisor_i;
      countQ   <= '0;
      runQ     <= 1'b1;
    end else if (abort_i) begin
      countQ   <= '0;
      runQ     <= 1'b0;
    end else if (runQ) begin
      remQ     <= remD;
      quoQ     <= quoD;
      countQ   <= countQ + 5'd1;
      if (countQ == LAST_STEP) begin
        runQ <= 1'b0;
      end
    end
  end

  assign quotient_o  = quoD;
  assign remainder_o = remD;
  assign done_o      = runQ && (countQ == LAST_STEP);

endmodule

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU complete in one cycle; DIV/DIVU use a 32-step iterative
// divider and stall the front of the pipeline while it runs. Also handles
// MFHI/MFLO (combinational read) and MTHI/MTLO.
//
// Optional feature macro: MULDIV_DIV_EN
//   defined   : divider, DIV/DONE states and the stall request are built.
//   undefined : DIV/DIVU are no-ops, busy is tied low, FSM stays in IDLE.
//
// Ports:
//   clk            pipeline clock
//   reset          synchronous active-high reset
//   exInstruction  instruction currently in EX
//   exReg1         rs value (dividend / multiplicand / MT source)
//   exReg2         rt value (divisor / multiplier)
//   flush          kill the EX instruction; aborts a divide in progress
//   busy           stall request to the IF/ID/EX stage registers
//   hi, lo         architectural HI/LO
//   mfResult       HI for MFHI, LO for MFLO, otherwise 0
// ---------------------------------------------------------------------------
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] exInstruction,
  input  logic [WORD-1:0] exReg1,
  input  logic [WORD-1:0] exReg2,
  input  logic            flush,
  output logic            busy,
  output logic [WORD-1:0] hi,
  output logic [WORD-1:0] lo,
  output logic [WORD-1:0] mfResult
);

  muldivState_e      stateQ;
  logic [WORD-1:0]   hiQ;
  logic [WORD-1:0]   loQ;
  muldivOp_e         op;
  logic              unusedInstrBits;
  logic [2*WORD-1:0] productSigned;
  logic [2*WORD-1:0] productUnsigned;

  // Only opcode and funct matter; the register/shamt fields are ignored.
  assign op              = decodeOp(exInstruction[31:26], exInstruction[5:0]);
  assign unusedInstrBits = ^exInstruction[25:6];

  assign productSigned   = $signed({{WORD{exReg1[WORD-1]}}, exReg1})
                         * $signed({{WORD{exReg2[WORD-1]}}, exReg2});
  assign productUnsigned = {{WORD{1'b0}}, exReg1} * {{WORD{1'b0}}, exReg2};

`ifdef MULDIV_DIV_EN
  localparam logic [WORD-1:0] MOST_NEGATIVE = {1'b1, {(WORD-1){1'b0}}};

  logic            isDivOp;
  logic            opSigned;
  logic            divStart;
  logic            divAbort;
  logic            divDone;
  logic [WORD-1:0] absDividend;
  logic [WORD-1:0] absDivisor;
  logic [WORD-1:0] divQuotient;
  logic [WORD-1:0] divRemainder;
  logic [WORD-1:0] divLoResult;
  logic [WORD-1:0] divHiResult;
  logic            negQuoQ;
  logic            negRemQ;
  logic            divZeroQ;
  logic            overflowQ;
  logic [WORD-1:0] dividendQ;

  assign isDivOp     = (op == OP_DIV) || (op == OP_DIVU);
  assign opSigned    = (op == OP_DIV);
  assign absDividend = (opSigned && exReg1[WORD-1]) ? -exReg1 : exReg1;
  assign absDivisor  = (opSigned && exReg2[WORD-1]) ? -exReg2 : exReg2;

  // A divide starts from IDLE; the stall must be raised in that same cycle
  // so the DIV instruction is held in EX for the whole iteration.
  assign divStart = (stateQ == ST_IDLE) && isDivOp && !flush;
  assign divAbort = (stateQ == ST_DIV) && flush;
  assign busy     = (stateQ == ST_DIV) || divStart;

  ex_muldiv_unit_div_iter divIter (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (divStart),
    .abort_i     (divAbort),
    .dividend_i  (absDividend),
    .divisor_i   (absDivisor),
    .quotient_o  (divQuotient),
    .remainder_o (divRemainder),
    .done_o      (divDone)
  );

  // Re-apply the signs to the magnitude result, then let the divide-by-zero
  // and overflow cases override. Divide-by-zero returns the original
  // (signed) dividend in HI, not its magnitude.
  always_comb begin
    divLoResult = negQuoQ ? -divQuotient : divQuotient;
    divHiResult = negRemQ ? -divRemainder : divRemainder;
    if (divZeroQ) begin
      divLoResult = '1;
      divHiResult = dividendQ;
    end else if (overflowQ) begin
      divLoResult = MOST_NEGATIVE;
      divHiResult = '0;
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Main FSM and HI/LO registers. Only IDLE executes new instructions; in
  // DIV and DONE the stalled DIV is still sitting in EX. DONE exists so that
  // the still-present DIV is not started a second time.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= ST_IDLE;
      hiQ       <= '0;
      loQ       <= '0;
`ifdef MULDIV_DIV_EN
      negQuoQ   <= 1'b0;
      negRemQ   <= 1'b0;
      divZeroQ  <= 1'b0;
      overflowQ <= 1'b0;
      dividendQ <= '0;
`endif
    end else begin
      case (stateQ)
        ST_IDLE: begin
          if (!flush) begin
            case (op)
              OP_MULT:  {hiQ, loQ} <= productSigned;
              OP_MULTU: {hiQ, loQ} <= productUnsigned;
              OP_MTHI:  hiQ <= exReg1;
              OP_MTLO:  loQ <= exReg1;
`ifdef MULDIV_DIV_EN
              OP_DIV, OP_DIVU: begin
                negQuoQ   <= opSigned && (exReg1[WORD-1] ^ exReg2[WORD-1]);
                negRemQ   <= opSigned && exReg1[WORD-1];
                divZeroQ  <= (exReg2 == '0);
                overflowQ <= opSigned && (exReg1 == MOST_NEGATIVE)
                                      && (exReg2 == '1);
                dividendQ <= exReg1;
                stateQ    <= ST_DIV;
              end
`endif
              default: ;
            endcase
          end
        end
`ifdef MULDIV_DIV_EN
        ST_DIV: begin
          if (flush) begin
            stateQ <= ST_IDLE;
          end else if (divDone) begin
            hiQ    <= divHiResult;
            loQ    <= divLoResult;
            stateQ <= ST_DONE;
          end
        end
        ST_DONE: stateQ <= ST_IDLE;
`endif
        default: stateQ <= ST_IDLE;
      endcase
    end
  end

  // MF reads see the register contents before any write this cycle.
  always_comb begin
    mfResult = '0;
    if (op == OP_MFHI) begin
      mfResult = hiQ;
    end else if (op == OP_MFLO) begin
      mfResult = loQ;
    end
  end

  assign hi = hiQ;
  assign lo = loQ;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Self-checking bench for ex_muldiv_unit. Expected HI/LO values come from a
// plain-arithmetic reference model (64-bit products, integer division with
// the divide-by-zero and overflow rules). Works with MULDIV_DIV_EN defined
// or undefined; without the divider, divides are expected to be no-ops.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN   = 1'b1;
  localparam int DIV_BUSY = 33;
`else
  localparam bit DIV_EN   = 1'b0;
  localparam int DIV_BUSY = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] exInstruction;
  logic [31:0] exReg1;
  logic [31:0] exReg2;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mfResult;

  int total = 0;
  int bad   = 0;

  logic [31:0] modelHi;
  logic [31:0] modelLo;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk           (clk),
    .reset         (reset),
    .exInstruction (exInstruction),
    .exReg1        (exReg1),
    .exReg2        (exReg2),
    .flush         (flush),
    .busy          (busy),
    .hi            (hi),
    .lo            (lo),
    .mfResult      (mfResult)
  );

  // SPECIAL-opcode instruction with random rs/rt/rd/shamt fields.
  function automatic logic [31:0] rType(input logic [5:0] funct);
    logic [31:0] r;
    r = $urandom();
    return {6'h00, r[25:6], funct};
  endfunction

  function automatic logic [63:0] modelProduct(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input bit sgn);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = a;
    ub = b;
    return ua * ub;
  endfunction

  task automatic modelDivide(input logic [31:0] a, input logic [31:0] b,
                             input bit sgn,
                             output logic [31:0] qLo, output logic [31:0] rHi);
    int sa, sb;
    if (b == 32'h0) begin
      qLo = 32'hFFFFFFFF;
      rHi = a;
    end else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      qLo = 32'h80000000;
      rHi = 32'h0;
    end else if (sgn) begin
      sa  = a;
      sb  = b;
      qLo = sa / sb;
      rHi = sa % sb;
    end else begin
      qLo = a / b;
      rHi = a % b;
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled 2ns after it.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a,
                               input logic [31:0] b, input logic fl);
    @(posedge clk);
    #1;
    exInstruction = instr;
    exReg1        = a;
    exReg2        = b;
    flush         = fl;
    #1;
  endtask

  // Issues a divide and holds it in EX while busy is high. Returns the
  // number of busy cycles; with the divider present it returns in DONE.
  task automatic doDivide(input logic [31:0] a, input logic [31:0] b,
                          input bit sgn, output int cycles);
    applyStimulus(rType(sgn ? F_DIV : F_DIVU), a, b, 1'b0);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    exInstruction = rType(F_MFLO);
    repeat (3) @(posedge clk);
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    total++; if (mfResult !== 32'h0) begin bad++; $display("[TB] FAIL reset_mf: got %h expected 0", mfResult); end
    @(posedge clk);
    #1;
    reset         = 1'b0;
    exInstruction = 32'h0;
    modelHi       = 32'h0;
    modelLo       = 32'h0;
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    bit          sgn;
    applyStimulus(rType(F_MULT), 32'hFFFFFFFF, 32'h2, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mult_busy: got %b expected 0", busy); end
    applyStimulus(rType(F_MULTU), 32'hFFFFFFFF, 32'h2, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL multu_busy: got %b expected 0", busy); end
    {modelHi, modelLo} = modelProduct(32'hFFFFFFFF, 32'h2, 1'b1);
    total++; if (hi !== modelHi) begin bad++; $display("[TB] FAIL mult_hi: got %h expected %h", hi, modelHi); end
    total++; if (lo !== modelLo) begin bad++; $display("[TB] FAIL mult_lo: got %h expected %h", lo, modelLo); end
    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0);
    {modelHi, modelLo} = modelProduct(32'hFFFFFFFF, 32'h2, 1'b0);
    total++; if (hi !== modelHi) begin bad++; $display("[TB] FAIL multu_hi: got %h expected %h", hi, modelHi); end
    total++; if (lo !== modelLo) begin bad++; $display("[TB] FAIL multu_lo: got %h expected %h", lo, modelLo); end
    // Back-to-back random multiplies: each cycle shows the previous product.
    for (int i = 0; i < 12; i++) begin
      a   = $urandom();
      b   = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      sgn = 1'($urandom_range(0, 1));
      applyStimulus(rType(sgn ? F_MULT : F_MULTU), a, b, 1'b0);
      total++; if (hi !== modelHi || lo !== modelLo || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL mult_rand%0d: got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", i, hi, lo, busy, modelHi, modelLo);
      end
      {modelHi, modelLo} = modelProduct(a, b, sgn);
    end
    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0);
    total++; if (hi !== modelHi || lo !== modelLo) begin
      bad++;
      $display("[TB] FAIL mult_last: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, modelHi, modelLo);
    end
  endtask

  task automatic test_mt_mf();
    logic [31:0] x, y, z;
    x = $urandom();
    y = $urandom();
    z = ~x ^ 32'h5A5A_0001;
    applyStimulus(rType(F_MTHI), x, z, 1'b0);
    applyStimulus(rType(F_MTLO), y, z, 1'b0);
    total++; if (hi !== x) begin bad++; $display("[TB] FAIL mthi: got %h expected %h", hi, x); end
    applyStimulus(rType(F_MFHI), z, z, 1'b0);
    total++; if (lo !== y) begin bad++; $display("[TB] FAIL mtlo: got %h expected %h", lo, y); end
    total++; if (mfResult !== x) begin bad++; $display("[TB] FAIL mfhi: got %h expected %h", mfResult, x); end
    applyStimulus(rType(F_MFLO), z, z, 1'b0);
    total++; if (mfResult !== y) begin bad++; $display("[TB] FAIL mflo: got %h expected %h", mfResult, y); end
    // Non-SPECIAL opcode carrying an MTHI funct must be ignored.
    applyStimulus({6'h23, 20'h0, F_MTHI}, z, z, 1'b0);
    total++; if (mfResult !== 32'h0) begin bad++; $display("[TB] FAIL mf_other: got %h expected 0", mfResult); end
    // Flushed writes must not land.
    applyStimulus(rType(F_MTLO), z, z, 1'b1);
    applyStimulus(rType(F_MULT), z, z, 1'b1);
    applyStimulus(rType(F_MFHI), z, z, 1'b0);
    total++; if (mfResult !== x) begin bad++; $display("[TB] FAIL flush_hi: got %h expected %h", mfResult, x); end
    applyStimulus(rType(F_MFLO), z, z, 1'b0);
    total++; if (mfResult !== y) begin bad++; $display("[TB] FAIL flush_lo: got %h expected %h", mfResult, y); end
    modelHi = x;
    modelLo = y;
  endtask

  task automatic test_divu();
    int cycles;
    doDivide(32'd100, 32'd7, 1'b0, cycles);
    total++; if (cycles != DIV_BUSY) begin bad++; $display("[TB] FAIL divu_busy_cycles: got %0d expected %0d", cycles, DIV_BUSY); end
    if (DIV_EN) modelDivide(32'd100, 32'd7, 1'b0, modelLo, modelHi);
    total++; if (hi !== modelHi) begin bad++; $display("[TB] FAIL divu_hi: got %h expected %h", hi, modelHi); end
    total++; if (lo !== modelLo) begin bad++; $display("[TB] FAIL divu_lo: got %h expected %h", lo, modelLo); end
    applyStimulus(rType(F_MFLO), 32'h0, 32'h0, 1'b0);
    total++; if (mfResult !== modelLo) begin bad++; $display("[TB] FAIL divu_mflo: got %h expected %h", mfResult, modelLo); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL divu_after_busy: got %b expected 0", busy); end
  endtask

  task automatic test_div_cases();
    logic [31:0] as [6];
    logic [31:0] bs [6];
    bit          ss [6];
    logic [31:0] a, b;
    bit          sgn;
    int          cycles;
    as = '{32'hFFFFFFF9, 32'h80000000, 32'h12345678, 32'h87654321, 32'h80000000, 32'h7FFFFFFF};
    bs = '{32'h00000002, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h80000000};
    ss = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      if (i < 6) begin
        a   = as[i];
        b   = bs[i];
        sgn = ss[i];
      end else begin
        a   = $urandom();
        sgn = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       b = 32'($urandom_range(1, 20));
          1:       b = $urandom();
          2:       b = 32'h0;
          default: b = -32'($urandom_range(1, 20));
        endcase
      end
      doDivide(a, b, sgn, cycles);
      if (DIV_EN) modelDivide(a, b, sgn, modelLo, modelHi);
      total++; if (cycles != DIV_BUSY || hi !== modelHi || lo !== modelLo) begin
        bad++;
        $display("[TB] FAIL div_case%0d (%h/%h s=%0d): got busy=%0d hi=%h lo=%h expected busy=%0d hi=%h lo=%h",
                 i, a, b, sgn, cycles, hi, lo, DIV_BUSY, modelHi, modelLo);
      end
    end
  endtask

  task automatic test_flush();
    logic expBusy;
    applyStimulus(rType(F_MTHI), 32'hDEADBEEF, 32'h0, 1'b0);
    modelHi = 32'hDEADBEEF;
    applyStimulus(rType(F_DIVU), 32'd9, 32'd3, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #2;
    end
    expBusy = DIV_EN;
    total++; if (busy !== expBusy) begin bad++; $display("[TB] FAIL flush_mid_busy: got %b expected %b", busy, expBusy); end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush         = 1'b0;
    exInstruction = 32'h0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
    total++; if (hi !== modelHi) begin bad++; $display("[TB] FAIL flush_div_hi: got %h expected %h", hi, modelHi); end
    total++; if (lo !== modelLo) begin bad++; $display("[TB] FAIL flush_div_lo: got %h expected %h", lo, modelLo); end
    repeat (30) @(posedge clk);
    #2;
    total++; if (hi !== modelHi || lo !== modelLo || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_late: got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", hi, lo, busy, modelHi, modelLo);
    end
  endtask

  task automatic test_reset_mid_div();
    int cycles;
    applyStimulus(rType(F_MTHI), $urandom() | 32'h1, 32'h0, 1'b0);
    applyStimulus(rType(F_MTLO), $urandom() | 32'h1, 32'h0, 1'b0);
    applyStimulus(rType(F_DIVU), 32'd1000, 32'd7, 1'b0);
    repeat (20) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    exInstruction = 32'h0;
    #1;
    modelHi = 32'h0;
    modelLo = 32'h0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstdiv_busy: got %b expected 0", busy); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("[TB] FAIL rstdiv_hilo: got hi=%h lo=%h expected 0/0", hi, lo); end
    doDivide(32'd10, 32'd3, 1'b0, cycles);
    if (DIV_EN) modelDivide(32'd10, 32'd3, 1'b0, modelLo, modelHi);
    total++; if (cycles != DIV_BUSY || hi !== modelHi || lo !== modelLo) begin
      bad++;
      $display("[TB] FAIL rstdiv_fresh: got busy=%0d hi=%h lo=%h expected busy=%0d hi=%h lo=%h", cycles, hi, lo, DIV_BUSY, modelHi, modelLo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int          cycles;
    for (int i = 0; i < 2; i++) begin
      a = $urandom();
      b = 32'($urandom_range(1, 1000));
      doDivide(a, b, i[0], cycles);
      if (DIV_EN) modelDivide(a, b, i[0], modelLo, modelHi);
      total++; if (cycles != DIV_BUSY || hi !== modelHi || lo !== modelLo) begin
        bad++;
        $display("[TB] FAIL b2b_div%0d: got busy=%0d hi=%h lo=%h expected busy=%0d hi=%h lo=%h", i, cycles, hi, lo, DIV_BUSY, modelHi, modelLo);
      end
    end
    applyStimulus(rType(F_MFHI), 32'h0, 32'h0, 1'b0);
    total++; if (mfResult !== modelHi) begin bad++; $display("[TB] FAIL b2b_mfhi: got %h expected %h", mfResult, modelHi); end
    a = $urandom();
    b = $urandom();
    applyStimulus(rType(F_MULT), a, b, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_mult_busy: got %b expected 0", busy); end
    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0);
    {modelHi, modelLo} = modelProduct(a, b, 1'b1);
    total++; if (hi !== modelHi || lo !== modelLo) begin
      bad++;
      $display("[TB] FAIL b2b_mult: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, modelHi, modelLo);
    end
  endtask

  // Backstop in case the DUT wedges somewhere the bounded waits do not cover.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    exInstruction = 32'h0;
    exReg1        = 32'h0;
    exReg2        = 32'h0;
    modelHi       = 32'h0;
    modelLo       = 32'h0;
    test_reset();
    test_mult();
    test_mt_mf();
    test_divu();
    test_div_cases();
    test_flush();
    test_reset_mid_div();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
